// File: rtl/output_port_arbiter.sv
// Output port arbiter: round-robin selection among NUM_IN input buffers into a
// single-entry output register, with optional hop decrement and valid/ready drain.
module output_port_arbiter #(
    parameter int unsigned NUM_IN  = 4,
    parameter bit          DEC_HOP = 1'b1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_IN-1:0]      req,
    input  logic [64*NUM_IN-1:0]   pkt_in,
    output logic [NUM_IN-1:0]      grant,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [63:0]            pkt_out,
    output logic [15:0]            pkt_count
);

    localparam int unsigned RR_W   = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;
    localparam int unsigned PKT_W  = 64;
    localparam int unsigned CNT_W  = 16;
    localparam int unsigned HOP_LO = 48;
    localparam int unsigned HOP_W  = 8;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [RR_W-1:0]   rr_q, rr_d;
    logic [PKT_W-1:0]  pkt_q, pkt_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [RR_W-1:0]   winner;
    logic [RR_W-1:0]   cand;
    logic              found;
    logic              can_load;
    logic              load;
    logic [PKT_W-1:0]  sel_pkt;

    // Round-robin search starting at rr_q; first requester in wrap order wins.
    always_comb begin
        winner = '0;
        cand   = '0;
        found  = 1'b0;
        for (int unsigned k = 0; k < NUM_IN; k++) begin
            cand = RR_W'((32'(rr_q) + k) % NUM_IN);
            if (!found && req[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    // Grant is suppressed during reset so upstream never clears a packet we drop.
    always_comb begin
        can_load = (state_q == EMPTY) || out_ready;
        load     = found && can_load && !reset;
        grant    = '0;
        if (load) begin
            grant[winner] = 1'b1;
        end
    end

    // Hop field saturates at zero rather than wrapping to 8'hFF.
    always_comb begin
        sel_pkt = pkt_in[PKT_W*winner +: PKT_W];
        if (DEC_HOP && (sel_pkt[HOP_LO +: HOP_W] != '0)) begin
            sel_pkt[HOP_LO +: HOP_W] = sel_pkt[HOP_LO +: HOP_W] - HOP_W'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        pkt_d   = pkt_q;
        cnt_d   = cnt_q;
        if (load) begin
            state_d = FULL;
            pkt_d   = sel_pkt;
            rr_d    = (32'(winner) == NUM_IN - 1) ? '0 : winner + RR_W'(1);
            cnt_d   = cnt_q + CNT_W'(1);
        end else if ((state_q == FULL) && out_ready) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= EMPTY;
            rr_q    <= '0;
            pkt_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            pkt_q   <= pkt_d;
            cnt_q   <= cnt_d;
        end
    end

    assign out_valid = (state_q == FULL);
    assign pkt_out   = pkt_q;
    assign pkt_count = cnt_q;

endmodule

// File: tb/tb_output_port_arbiter.sv
// Bench for output_port_arbiter: directed steps plus random traffic against a
// behavioural model; a router port (hop decrement) and a PE port share stimulus.
module tb_output_port_arbiter;

    localparam int N = 4;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   req;
    logic [64*N-1:0] pkt_in;
    logic           out_ready;

    logic [N-1:0]   grant_h, grant_p;
    logic           ov_h, ov_p;
    logic [63:0]    po_h, po_p;
    logic [15:0]    pc_h, pc_p;

    int total = 0;
    int bad   = 0;

    int          rr_m;
    bit          full_m;
    logic [63:0] pkt_h_m, pkt_p_m;
    int unsigned cnt_m;
    int          w_m;
    bit          load_m;

    output_port_arbiter #(.NUM_IN(N), .DEC_HOP(1'b1)) dut (
        .clk(clk), .reset(reset), .req(req), .pkt_in(pkt_in), .grant(grant_h),
        .out_valid(ov_h), .out_ready(out_ready), .pkt_out(po_h), .pkt_count(pc_h)
    );

    output_port_arbiter #(.NUM_IN(N), .DEC_HOP(1'b0)) dut_pe (
        .clk(clk), .reset(reset), .req(req), .pkt_in(pkt_in), .grant(grant_p),
        .out_valid(ov_p), .out_ready(out_ready), .pkt_out(po_p), .pkt_count(pc_p)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] hop(input logic [63:0] p, input bit dec);
        logic [63:0] r;
        r = p;
        if (dec && r[55:48] != 8'h00) r[55:48] = r[55:48] - 8'h01;
        return r;
    endfunction

    function automatic logic [64*N-1:0] rnd_pkts();
        logic [64*N-1:0] r;
        for (int i = 0; i < 2*N; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    task automatic model_reset();
        rr_m    = 0;
        full_m  = 1'b0;
        pkt_h_m = '0;
        pkt_p_m = '0;
        cnt_m   = 0;
    endtask

    // One clock: check everything at the negedge, then advance the model at the posedge.
    task automatic cycle(input string tag);
        logic [N-1:0] eg;
        @(negedge clk);
        w_m = -1;
        for (int k = 0; k < N; k++) begin
            int i = (rr_m + k) % N;
            if (w_m < 0 && req[i]) w_m = i;
        end
        load_m = (w_m >= 0) && (!full_m || out_ready);
        eg = '0;
        if (load_m) eg[w_m] = 1'b1;
        chk({tag, "_grant"},    64'(grant_h), 64'(eg));
        chk({tag, "_grant_pe"}, 64'(grant_p), 64'(eg));
        chk({tag, "_valid"},    64'(ov_h),    64'(full_m));
        chk({tag, "_valid_pe"}, 64'(ov_p),    64'(full_m));
        chk({tag, "_pkt"},      po_h,         pkt_h_m);
        chk({tag, "_pkt_pe"},   po_p,         pkt_p_m);
        chk({tag, "_count"},    64'(pc_h),    64'(cnt_m));
        @(posedge clk);
        if (load_m) begin
            pkt_h_m = hop(pkt_in[64*w_m +: 64], 1'b1);
            pkt_p_m = pkt_in[64*w_m +: 64];
            full_m  = 1'b1;
            rr_m    = (w_m + 1) % N;
            cnt_m   = (cnt_m + 1) % 65536;
        end else if (full_m && out_ready) begin
            full_m = 1'b0;
        end
        #1;
    endtask

    initial begin
        reset = 1'b0; req = '0; pkt_in = '0; out_ready = 1'b0;
        model_reset();
        #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        // Reset state, with every input requesting
        req = 4'hF;
        #1;
        chk("rst_grant", 64'(grant_h), 64'h0);
        chk("rst_valid", 64'(ov_h), 64'h0);
        chk("rst_pkt",   po_h, 64'h0);
        chk("rst_count", 64'(pc_h), 64'h0);

        // Single capture with hop decrement
        reset = 1'b0;
        req = 4'b0001;
        pkt_in[63:0] = 64'h0003_0000_0000_00AA;
        #1;
        chk("tp1_grant_c", 64'(grant_h), 64'h1);
        cycle("tp1");
        req = '0;
        #1;
        chk("tp1_valid_c", 64'(ov_h), 64'h1);
        chk("tp1_pkt_c",   po_h, 64'h0002_0000_0000_00AA);
        chk("tp1_pkt_pe_c", po_p, 64'h0003_0000_0000_00AA);
        chk("tp1_count_c", 64'(pc_h), 64'h1);

        // Bring rr back to 0, then all-request rotation at full rate
        out_ready = 1'b1;
        req = 4'b1000;
        pkt_in = rnd_pkts();
        cycle("rr0");
        req = 4'hF;
        for (int i = 0; i < 5; i++) begin
            pkt_in = rnd_pkts();
            #1;
            chk("rot_grant_c", 64'(grant_h), 64'(4'b0001 << (i % 4)));
            chk("rot_valid_c", 64'(ov_h), 64'h1);
            cycle("rot");
        end

        // Backpressure hold, then release
        out_ready = 1'b0;
        req = 4'b0100;
        for (int i = 0; i < 5; i++) begin
            pkt_in = rnd_pkts();
            #1;
            chk("hold_grant_c", 64'(grant_h), 64'h0);
            cycle("hold");
        end
        pkt_in = rnd_pkts();
        out_ready = 1'b1;
        #1;
        chk("rel_grant_c", 64'(grant_h), 64'h4);
        cycle("rel");
        chk("rel_pkt_c", po_h, hop(pkt_in[191:128], 1'b1));

        // Hop field boundaries
        req = 4'b0001;
        pkt_in[63:0] = 64'h1200_3456_789A_BCDE;
        cycle("hop0");
        chk("hop0_pkt_c",    po_h, 64'h1200_3456_789A_BCDE);
        chk("hop0_pkt_pe_c", po_p, 64'h1200_3456_789A_BCDE);
        pkt_in[63:0] = 64'h0005_1111_2222_3333;
        cycle("hop5");
        chk("hop5_pkt_c",    po_h, 64'h0004_1111_2222_3333);
        chk("hop5_pkt_pe_c", po_p, 64'h0005_1111_2222_3333);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            req = 4'($urandom);
            pkt_in = rnd_pkts();
            out_ready = ($urandom_range(0, 3) != 0);
            cycle("rnd");
        end

        // Asynchronous reset between edges while holding a packet
        req = 4'b0001;
        out_ready = 1'b1;
        pkt_in = rnd_pkts();
        cycle("pre_arst");
        req = 4'hF;
        #2 reset = 1'b1;
        #1;
        chk("arst_valid",    64'(ov_h), 64'h0);
        chk("arst_valid_pe", 64'(ov_p), 64'h0);
        chk("arst_pkt",      po_h, 64'h0);
        chk("arst_count",    64'(pc_h), 64'h0);
        chk("arst_grant",    64'(grant_h), 64'h0);
        model_reset();
        req = '0;
        #2 reset = 1'b0;
        @(posedge clk);
        #1;
        req = 4'hF;
        #1;
        chk("restart_grant_c", 64'(grant_h), 64'h1);
        cycle("restart");

        // Counter wrap with continuous forwarding
        out_ready = 1'b1;
        for (int i = 0; i < 65535; i++) begin
            req = 4'($urandom_range(1, 15));
            pkt_in = rnd_pkts();
            cycle("wrap");
        end
        chk("wrap_count_c", 64'(pc_h), 64'h0);
        chk("wrap_valid_c", 64'(ov_h), 64'h1);
        req = 4'b0010;
        cycle("post_wrap");
        chk("post_wrap_count_c", 64'(pc_h), 64'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
